// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared widths and response-owner encoding for mem_port_arbiter
package mem_arb_pkg;
  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;
  typedef enum logic [1:0] {RESP_NONE = 2'd0, RESP_IF = 2'd1, RESP_D = 2'd2} resp_t;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: IF/D sharing of a 1R1W memory; D-priority reads, round-robin when MEM_ARB_RR_EN is defined
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rd_data
);
  logic d_rd, d_wins, rd_d, rd_if;
  logic [ADDR_W-1:0] rd_addr_q;
  resp_t resp_owner, resp_next;
  assign d_rd = d_req & ~d_we;
`ifdef MEM_ARB_RR_EN
  logic last_d;
  assign d_wins = ~last_d;
  always_ff @(posedge clk)
    if (rst) last_d <= 1'b0;
    else if (if_req && d_rd) last_d <= d_wins;
`else
  assign d_wins = 1'b1;
`endif
  always_comb begin
    rd_d        = ~rst & d_rd & (~if_req | d_wins);
    rd_if       = ~rst & if_req & (~d_rd | ~d_wins);
    mem_we      = ~rst & d_req & d_we;
    d_gnt       = rd_d | mem_we;
    if_gnt      = rd_if;
    mem_wr_addr = d_addr;
    mem_wdata   = d_wdata;
    mem_rd_addr = rd_d ? d_addr : rd_if ? if_addr : rd_addr_q;
    resp_next   = rd_d ? RESP_D : rd_if ? RESP_IF : RESP_NONE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      resp_owner <= RESP_NONE;
      rd_addr_q  <= '0;
    end else begin
      resp_owner <= resp_next;
      rd_addr_q  <= mem_rd_addr;
    end
  assign if_rvalid = ~rst & (resp_owner == RESP_IF);
  assign d_rvalid  = ~rst & (resp_owner == RESP_D);
  assign if_rdata  = if_rvalid ? mem_rd_data : '0;
  assign d_rdata   = d_rvalid ? mem_rd_data : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against a memory and grant reference model
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic if_gnt, if_rvalid, d_gnt, d_rvalid, mem_we;
  logic [31:0] if_rdata, d_rdata, mem_rd_addr, mem_wr_addr, mem_wdata;
  logic [31:0] mem_rd_data = '0;
  logic [31:0] mem [0:63];
  logic loaded = 1'b0;
  logic [31:0] exp_mem [0:63];
  logic last_d_m;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_rd_addr(mem_rd_addr), .mem_wr_addr(mem_wr_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rd_data(mem_rd_data)
  );

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h100 + i;
      loaded <= 1'b1;
    end else begin
      if (mem_we) mem[mem_wr_addr[5:0]] <= mem_wdata;
      mem_rd_data <= mem[mem_rd_addr[5:0]];
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic d_wins_conflict();
`ifdef MEM_ARB_RR_EN
    return !last_d_m;
`else
    return 1'b1;
`endif
  endfunction

  task automatic test_reset;
    rst = 1'b1; if_req = 1'b1; if_addr = 32'd4; d_req = 1'b1; d_we = 1'b1; d_addr = 32'd4; d_wdata = 32'h77;
    tick(); tick();
    total++; if (if_gnt !== 1'b0) begin bad++; $display("FAIL reset_if_gnt got %b want 0", if_gnt); end
    total++; if (d_gnt !== 1'b0) begin bad++; $display("FAIL reset_d_gnt got %b want 0", d_gnt); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
    total++; if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid got %b%b want 00", if_rvalid, d_rvalid); end
    total++; if (mem_rd_addr !== 32'd0) begin bad++; $display("FAIL reset_rd_addr got %h want 0", mem_rd_addr); end
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; last_d_m = 1'b0;
    tick();
  endtask

  task automatic test_if_single;
    if_req = 1'b1; if_addr = 32'd5;
    #1;
    total++; if (if_gnt !== 1'b1) begin bad++; $display("FAIL single_if_gnt got %b want 1", if_gnt); end
    total++; if (mem_rd_addr !== 32'd5) begin bad++; $display("FAIL single_rd_addr got %h want 5", mem_rd_addr); end
    tick();
    if_req = 1'b0;
    total++; if (if_rvalid !== 1'b1) begin bad++; $display("FAIL single_if_rvalid got %b want 1", if_rvalid); end
    total++; if (if_rdata !== exp_mem[5]) begin bad++; $display("FAIL single_if_rdata got %h want %h", if_rdata, exp_mem[5]); end
    total++; if (d_rvalid !== 1'b0) begin bad++; $display("FAIL single_d_rvalid got %b want 0", d_rvalid); end
    tick();
  endtask

  task automatic test_conflict;
    if_req = 1'b1; if_addr = 32'd3; d_req = 1'b1; d_we = 1'b0; d_addr = 32'd7;
    #1;
    total++; if (d_gnt !== 1'b1 || if_gnt !== 1'b0) begin bad++; $display("FAIL conflict_gnt got d=%b if=%b want d=1 if=0", d_gnt, if_gnt); end
    last_d_m = 1'b1;
    tick();
    d_req = 1'b0;
    #1;
    total++; if (d_rvalid !== 1'b1 || d_rdata !== exp_mem[7]) begin bad++; $display("FAIL conflict_d_rdata got v=%b %h want v=1 %h", d_rvalid, d_rdata, exp_mem[7]); end
    total++; if (if_gnt !== 1'b1) begin bad++; $display("FAIL conflict_if_retry got %b want 1", if_gnt); end
    tick();
    if_req = 1'b0;
    total++; if (if_rvalid !== 1'b1 || if_rdata !== exp_mem[3]) begin bad++; $display("FAIL conflict_if_rdata got v=%b %h want v=1 %h", if_rvalid, if_rdata, exp_mem[3]); end
    tick();
  endtask

  task automatic test_write_read_same;
    if_req = 1'b1; if_addr = 32'd9; d_req = 1'b1; d_we = 1'b1; d_addr = 32'd9; d_wdata = 32'hDEAD;
    #1;
    total++; if (d_gnt !== 1'b1 || if_gnt !== 1'b1) begin bad++; $display("FAIL wr_same_gnt got d=%b if=%b want 11", d_gnt, if_gnt); end
    total++; if (mem_we !== 1'b1 || mem_wr_addr !== 32'd9 || mem_wdata !== 32'hDEAD) begin bad++; $display("FAIL wr_same_port got we=%b a=%h d=%h want 1 9 dead", mem_we, mem_wr_addr, mem_wdata); end
    tick();
    d_req = 1'b0; d_we = 1'b0;
    total++; if (if_rdata !== 32'h109 || d_rvalid !== 1'b0) begin bad++; $display("FAIL wr_same_old got %h dv=%b want 109 dv=0", if_rdata, d_rvalid); end
    exp_mem[9] = 32'hDEAD;
    tick();
    if_req = 1'b0;
    total++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hDEAD) begin bad++; $display("FAIL wr_then_read got v=%b %h want v=1 dead", if_rvalid, if_rdata); end
    tick();
  endtask

  task automatic test_back_to_back;
    logic w, prev_w;
    rst = 1'b1; tick(); rst = 1'b0; last_d_m = 1'b0;
    if_req = 1'b1; if_addr = 32'd1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'd2;
    prev_w = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      w = d_wins_conflict();
      total++; if (d_gnt !== w || if_gnt !== !w) begin bad++; $display("FAIL b2b_gnt%0d got d=%b if=%b want d=%b if=%b", i, d_gnt, if_gnt, w, !w); end
      last_d_m = w;
      prev_w = w;
      tick();
      total++; if (d_rvalid !== prev_w || if_rvalid !== !prev_w || (prev_w ? d_rdata : if_rdata) !== exp_mem[prev_w ? 2 : 1])
        begin bad++; $display("FAIL b2b_resp%0d got dv=%b iv=%b d=%h i=%h want dv=%b", i, d_rvalid, if_rvalid, d_rdata, if_rdata, prev_w); end
    end
    if_req = 1'b0; d_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_drop;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'd4;
    #1;
    total++; if (d_gnt !== 1'b1) begin bad++; $display("FAIL drop_pre_gnt got %b want 1", d_gnt); end
    tick();
    rst = 1'b1; d_we = 1'b1; d_wdata = 32'h55; if_req = 1'b1; if_addr = 32'd8;
    #1;
    total++; if (mem_we !== 1'b0 || d_gnt !== 1'b0 || if_gnt !== 1'b0) begin bad++; $display("FAIL drop_rst_gnt got we=%b d=%b if=%b want 000", mem_we, d_gnt, if_gnt); end
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (d_rvalid !== 1'b0 || if_rvalid !== 1'b0 || mem_we !== 1'b0) begin bad++; $display("FAIL drop_rvalid%0d got dv=%b iv=%b we=%b want 000", i, d_rvalid, if_rvalid, mem_we); end
    end
    rst = 1'b0; d_we = 1'b0; d_addr = 32'd6; last_d_m = 1'b0;
    #1;
    total++; if (d_gnt !== 1'b1 || if_gnt !== 1'b0) begin bad++; $display("FAIL drop_first_conflict got d=%b if=%b want d=1 if=0", d_gnt, if_gnt); end
    last_d_m = 1'b1;
    tick();
    d_req = 1'b0; if_req = 1'b0;
    total++; if (d_rdata !== exp_mem[6]) begin bad++; $display("FAIL drop_post_rdata got %h want %h", d_rdata, exp_mem[6]); end
    tick();
  endtask

  task automatic test_random;
    logic eg_i, eg_d, nv_i, nv_d, w;
    logic [31:0] ndata;
    eg_i = 1'b0; eg_d = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (!if_req || eg_i) begin if_req = 1'($urandom_range(0, 1)); if_addr = 32'($urandom_range(0, 15)); end
      if (!d_req || eg_d) begin
        d_req = 1'($urandom_range(0, 1)); d_we = 1'($urandom_range(0, 1));
        d_addr = 32'($urandom_range(0, 15)); d_wdata = $urandom;
      end
      #1;
      if (if_req && d_req && !d_we) begin
        w = d_wins_conflict();
        eg_d = w; eg_i = !w; last_d_m = w;
      end else begin
        eg_d = d_req; eg_i = if_req;
      end
      total++; if (d_gnt !== eg_d || if_gnt !== eg_i || mem_we !== (d_req && d_we))
        begin bad++; $display("FAIL rand_gnt%0d got d=%b if=%b we=%b want d=%b if=%b we=%b", n, d_gnt, if_gnt, mem_we, eg_d, eg_i, d_req && d_we); end
      nv_d = eg_d && !d_we;
      nv_i = eg_i;
      ndata = nv_d ? exp_mem[d_addr[5:0]] : nv_i ? exp_mem[if_addr[5:0]] : 32'd0;
      if (d_req && d_we) exp_mem[d_addr[5:0]] = d_wdata;
      tick();
      total++; if (if_rvalid !== nv_i || d_rvalid !== nv_d || if_rdata !== (nv_i ? ndata : 32'd0) || d_rdata !== (nv_d ? ndata : 32'd0))
        begin bad++; $display("FAIL rand_resp%0d got iv=%b dv=%b i=%h d=%h want iv=%b dv=%b data=%h", n, if_rvalid, d_rvalid, if_rdata, d_rdata, nv_i, nv_d, ndata); end
    end
    if_req = 1'b0; d_req = 1'b0;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) exp_mem[i] = 32'h100 + i;
    last_d_m = 1'b0;
    test_reset();
    test_if_single();
    test_conflict();
    test_write_read_same();
    test_back_to_back();
    test_reset_drop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
